// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encodings,
// default reset PC and timeout, and a small alignment helper.
package fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH_IDLE  = 3'd0,
        FETCH_FETCH = 3'd1,
        FETCH_DROP  = 3'd2,
        FETCH_FULL  = 3'd3,
        FETCH_FAULT = 3'd4
    } fetch_state_t;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_3000;
    localparam int unsigned FETCH_MAX_WAIT = 15;

    // Word alignment check on the two low address bits.
    function automatic logic is_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction memory handshake, decode output buffer,
// redirect input from npc and the sticky fault flag.
interface fetch_ctrl_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fault;

    // fetch_ctrl side
    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, fault,
        input  imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc
    );

    // memory / decode / core-control side
    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, fault,
        output imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/fetch_ctrl_wait_timer.sv
// Counts consecutive unacknowledged request cycles. expired is asserted in the
// cycle whose edge would bring the count to MAX_WAIT, so the caller can act on
// that same edge. MAX_WAIT=0 disables the timeout.
module wait_timer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic count_en,
    input  logic clear,
    output logic expired
);

    localparam int unsigned    CW   = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    localparam logic [CW-1:0]  LAST = (MAX_WAIT == 0) ? '0 : CW'(MAX_WAIT - 1);

    logic [CW-1:0] r_cnt;

    // Wait counter: clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_cnt <= '0;
        else if (clear)    r_cnt <= '0;
        else if (count_en) r_cnt <= r_cnt + 1'b1;
    end

    assign expired = (MAX_WAIT != 0) && count_en && (r_cnt == LAST);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem req/ack handshake,
// buffers one fetched word for decode, applies redirects and flags faults.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
    parameter int unsigned MAX_WAIT = FETCH_MAX_WAIT
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_ctrl_if.master  bus
);

    fetch_state_t r_state, w_state_nx;
    logic [31:0]  r_pc, w_pc_nx;
    logic [31:0]  r_addr_q, w_addr_nx;
    logic [31:0]  r_instr, w_instr_nx;
    logic [31:0]  r_instr_pc, w_instr_pc_nx;
    logic         r_instr_valid, w_instr_valid_nx;
    logic         w_req;
    logic         w_expired;
    logic         w_redir_ok;

    // Request is a pure decode of registered state.
    assign w_req      = (r_state == FETCH_FETCH) || (r_state == FETCH_DROP);
    assign w_redir_ok = is_aligned(bus.redirect_pc[1:0]);

    wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .count_en (w_req && !bus.imem_ack),
        .clear    (bus.imem_ack),
        .expired  (w_expired)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= FETCH_IDLE;
            r_pc          <= RESET_PC;
            r_addr_q      <= RESET_PC;
            r_instr       <= '0;
            r_instr_pc    <= RESET_PC;
            r_instr_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_pc          <= w_pc_nx;
            r_addr_q      <= w_addr_nx;
            r_instr       <= w_instr_nx;
            r_instr_pc    <= w_instr_pc_nx;
            r_instr_valid <= w_instr_valid_nx;
        end
    end

    // Next-state logic; fault conditions first, then redirect, then handshake.
    always_comb begin
        w_state_nx       = r_state;
        w_pc_nx          = r_pc;
        w_addr_nx        = r_addr_q;
        w_instr_nx       = r_instr;
        w_instr_pc_nx    = r_instr_pc;
        w_instr_valid_nx = r_instr_valid;
        unique case (r_state)
            FETCH_IDLE: begin
                w_state_nx = FETCH_FETCH;
                w_addr_nx  = r_pc;
            end
            FETCH_FETCH: begin
                if (w_expired || (bus.redirect_valid && !w_redir_ok)) begin
                    w_state_nx       = FETCH_FAULT;
                    w_instr_valid_nx = 1'b0;
                end else if (bus.redirect_valid) begin
                    w_instr_valid_nx = 1'b0;
                    w_pc_nx          = bus.redirect_pc;
                    if (bus.imem_ack) w_addr_nx  = bus.redirect_pc;
                    else              w_state_nx = FETCH_DROP;
                end else if (bus.imem_ack) begin
                    w_instr_nx       = bus.imem_rdata;
                    w_instr_pc_nx    = r_addr_q;
                    w_instr_valid_nx = 1'b1;
                    w_pc_nx          = r_addr_q + 32'd4;
                    w_state_nx       = FETCH_FULL;
                end
            end
            FETCH_DROP: begin
                if (w_expired || (bus.redirect_valid && !w_redir_ok)) begin
                    w_state_nx       = FETCH_FAULT;
                    w_instr_valid_nx = 1'b0;
                end else if (bus.redirect_valid) begin
                    w_pc_nx = bus.redirect_pc;
                    // The stale request completes here; without this the
                    // sequencer would wait forever for a second ack.
                    if (bus.imem_ack) begin
                        w_addr_nx  = bus.redirect_pc;
                        w_state_nx = FETCH_FETCH;
                    end
                end else if (bus.imem_ack) begin
                    w_addr_nx  = r_pc;
                    w_state_nx = FETCH_FETCH;
                end
            end
            FETCH_FULL: begin
                if (bus.redirect_valid && !w_redir_ok) begin
                    w_state_nx       = FETCH_FAULT;
                    w_instr_valid_nx = 1'b0;
                end else if (bus.redirect_valid) begin
                    w_instr_valid_nx = 1'b0;
                    w_pc_nx          = bus.redirect_pc;
                    w_addr_nx        = bus.redirect_pc;
                    w_state_nx       = FETCH_FETCH;
                end else if (bus.instr_ready) begin
                    w_instr_valid_nx = 1'b0;
                    w_addr_nx        = r_pc;
                    w_state_nx       = FETCH_FETCH;
                end
            end
            FETCH_FAULT: begin
                w_state_nx = FETCH_FAULT;
            end
            default: begin
                w_state_nx       = FETCH_FAULT;
                w_instr_valid_nx = 1'b0;
            end
        endcase
    end

    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = r_addr_q;
    assign bus.instr_valid = r_instr_valid;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.fault       = (r_state == FETCH_FAULT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: streaming fetch, back-pressure, redirects
// with and without a same-cycle ack, misaligned redirect, timeout boundary,
// PC wrap-around and asynchronous reset mid-request.
module tb_fetch_ctrl;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    fetch_ctrl_if bus();

    fetch_ctrl #(.RESET_PC(32'h0000_3000), .MAX_WAIT(15)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic ack, input logic [31:0] rdata, input logic rdy,
                          input logic rv, input logic [31:0] rpc);
        bus.imem_ack       = ack;
        bus.imem_rdata     = rdata;
        bus.instr_ready    = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
    endtask

    // Reset, check reset values, release and step into the first FETCH.
    task automatic do_reset();
        rst_n = 1'b0;
        set_in(1'b0, '0, 1'b0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",   {31'd0, bus.imem_req},    32'd0);
        chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_fault", {31'd0, bus.fault},       32'd0);
        chk("rst_addr",  bus.imem_addr,            32'h0000_3000);
        chk("rst_ipc",   bus.instr_pc,             32'h0000_3000);
        chk("rst_instr", bus.instr,                32'd0);
        rst_n = 1'b1;
        step();
        chk("first_req",  {31'd0, bus.imem_req}, 32'd1);
        chk("first_addr", bus.imem_addr,         32'h0000_3000);
    endtask

    initial begin
        logic [31:0] a;
        n_chk = 0;
        n_err = 0;
        do_reset();

        // Zero-wait memory, decode always ready: one instruction per 2 cycles.
        for (int k = 0; k < 3; k++) begin
            a = 32'h0000_3000 + 32'(4 * k);
            chk("str_req",  {31'd0, bus.imem_req}, 32'd1);
            chk("str_addr", bus.imem_addr, a);
            set_in(1'b1, dat(a), 1'b1, 1'b0, '0);
            step();
            chk("str_valid", {31'd0, bus.instr_valid}, 32'd1);
            chk("str_instr", bus.instr, dat(a));
            chk("str_ipc",   bus.instr_pc, a);
            chk("str_req0",  {31'd0, bus.imem_req}, 32'd0);
            step();
        end

        // Back-pressure: buffer held for 5 cycles, no request.
        chk("bp_addr", bus.imem_addr, 32'h0000_300C);
        set_in(1'b1, dat(32'h300C), 1'b0, 1'b0, '0);
        step();
        bus.imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_req0",  {31'd0, bus.imem_req}, 32'd0);
            chk("bp_instr", bus.instr, dat(32'h300C));
            step();
        end
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        chk("bp_next_req",  {31'd0, bus.imem_req}, 32'd1);
        chk("bp_next_addr", bus.imem_addr, 32'h0000_3010);

        // Redirect while request for 0x3010 waits: address held, data dropped.
        step();
        chk("drop_wait_addr", bus.imem_addr, 32'h0000_3010);
        set_in(1'b0, '0, 1'b0, 1'b1, 32'h0000_3100);
        step();
        bus.redirect_valid = 1'b0;
        chk("drop_req",   {31'd0, bus.imem_req}, 32'd1);
        chk("drop_addr",  bus.imem_addr, 32'h0000_3010);
        step();
        chk("drop_addr2", bus.imem_addr, 32'h0000_3010);
        set_in(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, '0);
        step();
        chk("drop_valid0", {31'd0, bus.instr_valid}, 32'd0);
        chk("drop_new_req",  {31'd0, bus.imem_req}, 32'd1);
        chk("drop_new_addr", bus.imem_addr, 32'h0000_3100);
        bus.imem_rdata = dat(32'h3100);
        step();
        chk("drop_fill_ipc",   bus.instr_pc, 32'h0000_3100);
        chk("drop_fill_instr", bus.instr, dat(32'h3100));
        bus.instr_ready = 1'b1;
        step();
        chk("drop_seq_addr", bus.imem_addr, 32'h0000_3104);

        // Redirect in the same cycle as ack: data discarded, refetch at target.
        set_in(1'b1, dat(32'h3104), 1'b0, 1'b1, 32'h0000_3200);
        step();
        bus.redirect_valid = 1'b0;
        chk("racq_valid0", {31'd0, bus.instr_valid}, 32'd0);
        chk("racq_req",    {31'd0, bus.imem_req}, 32'd1);
        chk("racq_addr",   bus.imem_addr, 32'h0000_3200);
        bus.imem_rdata = dat(32'h3200);
        step();
        chk("racq_ipc", bus.instr_pc, 32'h0000_3200);

        // Redirect while buffer full with a same-cycle ready.
        set_in(1'b0, '0, 1'b1, 1'b1, 32'h0000_3300);
        step();
        bus.redirect_valid = 1'b0;
        bus.instr_ready    = 1'b0;
        chk("rfull_valid0", {31'd0, bus.instr_valid}, 32'd0);
        chk("rfull_addr",   bus.imem_addr, 32'h0000_3300);
        set_in(1'b1, dat(32'h3300), 1'b1, 1'b0, '0);
        step();
        chk("rfull_ipc", bus.instr_pc, 32'h0000_3300);
        step();
        bus.imem_ack    = 1'b0;
        bus.instr_ready = 1'b0;
        chk("rfull_next", bus.imem_addr, 32'h0000_3304);

        // Timeout boundary: ack on the 15th request cycle avoids fault.
        repeat (14) step();
        chk("to_edge_fault", {31'd0, bus.fault}, 32'd0);
        chk("to_edge_req",   {31'd0, bus.imem_req}, 32'd1);
        set_in(1'b1, dat(32'h3304), 1'b0, 1'b0, '0);
        step();
        chk("to_edge_valid",  {31'd0, bus.instr_valid}, 32'd1);
        chk("to_edge_fault2", {31'd0, bus.fault}, 32'd0);
        set_in(1'b0, '0, 1'b1, 1'b0, '0);
        step();
        bus.instr_ready = 1'b0;
        chk("to_addr", bus.imem_addr, 32'h0000_3308);
        // No ack at all: fault after 15 request cycles.
        repeat (14) step();
        chk("to_pre_fault", {31'd0, bus.fault}, 32'd0);
        step();
        chk("to_fault",  {31'd0, bus.fault}, 32'd1);
        chk("to_req0",   {31'd0, bus.imem_req}, 32'd0);
        chk("to_valid0", {31'd0, bus.instr_valid}, 32'd0);

        // Misaligned redirect faults; later activity ignored.
        do_reset();
        set_in(1'b1, dat(32'h3000), 1'b0, 1'b0, '0);
        step();
        set_in(1'b0, '0, 1'b0, 1'b1, 32'h0000_3102);
        step();
        chk("mis_fault",  {31'd0, bus.fault}, 32'd1);
        chk("mis_req0",   {31'd0, bus.imem_req}, 32'd0);
        chk("mis_valid0", {31'd0, bus.instr_valid}, 32'd0);
        set_in(1'b1, 32'h1234_5678, 1'b1, 1'b1, 32'h0000_3400);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mis_sticky", {31'd0, bus.fault}, 32'd1);
            chk("mis_noreq",  {31'd0, bus.imem_req}, 32'd0);
        end

        // PC wrap-around: 0xFFFF_FFFC + 4 = 0.
        do_reset();
        set_in(1'b1, dat(32'h3000), 1'b0, 1'b0, '0);
        step();
        set_in(1'b0, '0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step();
        chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
        set_in(1'b1, dat(32'hFFFF_FFFC), 1'b0, 1'b0, '0);
        step();
        chk("wrap_ipc", bus.instr_pc, 32'hFFFF_FFFC);
        set_in(1'b0, '0, 1'b1, 1'b0, '0);
        step();
        bus.instr_ready = 1'b0;
        chk("wrap_next", bus.imem_addr, 32'h0000_0000);
        chk("wrap_req",  {31'd0, bus.imem_req}, 32'd1);

        // Asynchronous reset mid-request; a late ack is ignored in IDLE.
        rst_n = 1'b0;
        #1;
        chk("arst_req0", {31'd0, bus.imem_req}, 32'd0);
        chk("arst_addr", bus.imem_addr, 32'h0000_3000);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hBAD0_BAD0;
        step();
        chk("arst_hold", {31'd0, bus.imem_req}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("arst_req1",   {31'd0, bus.imem_req}, 32'd1);
        chk("arst_valid0", {31'd0, bus.instr_valid}, 32'd0);
        chk("arst_addr2",  bus.imem_addr, 32'h0000_3000);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
